// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame deserialiser with
// parity/stop/timeout checks, E0/F0 prefix folding and a show-ahead event FIFO.
module ps2_kbd_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 56000,
  parameter int FIFO_AW    = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  input  logic       rd,
  output logic       valid,
  output logic [7:0] code,
  output logic       release_btn,
  output logic       extended,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [7:0]         FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [16:0]        TMO_MAX  = 17'(TIMEOUT);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic       clk_p0, clk_p1, data_p0, data_p1;
  logic [7:0] filt_cnt;
  logic       filt_clk, filt_prev, fall;

  // Stage 0/1: pin synchronisers, then clock glitch filter
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_p0    <= 1'b1;
      clk_p1    <= 1'b1;
      data_p0   <= 1'b1;
      data_p1   <= 1'b1;
      filt_cnt  <= '0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      clk_p0    <= ps2_kbd_clk;
      clk_p1    <= clk_p0;
      data_p0   <= ps2_kbd_data;
      data_p1   <= data_p0;
      filt_prev <= filt_clk;
      if (clk_p1 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        filt_clk <= clk_p1;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 8'd1;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  state_t      state, state_next;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par_bit;
  logic [16:0] tmo_cnt;
  logic        timeout, accept, bad_par, bad_stop;

  assign timeout = (state != IDLE) && (tmo_cnt == TMO_MAX);

  // Stage 2: frame FSM, evaluated on filtered falling edges
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    bad_par    = 1'b0;
    bad_stop   = 1'b0;
    if (timeout) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_p1) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          if (^{shift, par_bit} == 1'b0) bad_par  = 1'b1;
          else if (!data_p1)             bad_stop = 1'b1;
          else                           accept   = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE || fall) tmo_cnt <= '0;
      else                       tmo_cnt <= tmo_cnt + 17'd1;
      if (fall) begin
        if (state == IDLE)      bit_cnt <= '0;
        else if (state == DATA) bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (fall && state == DATA)   shift   <= {data_p1, shift[7:1]};
    if (fall && state == PARITY) par_bit <= data_p1;
  end

  logic ext_pend, rel_pend, push;

  assign push = accept && (shift != 8'hE0) && (shift != 8'hF0);

  // Stage 3: prefix folding and error pulses
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_pend   <= 1'b0;
      rel_pend   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= bad_par;
      frame_err  <= bad_stop | timeout;
      if (bad_par || bad_stop || timeout) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (accept) begin
        if (shift == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shift == 8'hF0) begin
          rel_pend <= 1'b1;
        end else begin
          ext_pend <= 1'b0;
          rel_pend <= 1'b0;
        end
      end
    end
  end

  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               pop, full, wr_en;

  assign valid = (count != '0);
  assign pop   = rd && valid;
  assign full  = (count == FULL_CNT);
  assign wr_en = push && (!full || pop);

  // Stage 4: show-ahead event FIFO
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr] <= {ext_pend, rel_pend, shift};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Empty FIFO presents zeros so the head outputs are defined out of reset
  assign {extended, release_btn, code} = valid ? mem[rd_ptr] : 10'd0;

endmodule
